// File: rtl/stopwatch_counter_pkg.sv
// stopwatch_counter_pkg
//   Shared constants for the stopwatch datapath and the mode FSM that drives
//   it: bit positions inside the mode vector and the per-field wrap value.
package stopwatch_counter_pkg;

    // Mode vector bit positions
    localparam int MODE_PAUSE = 0;
    localparam int MODE_SEL   = 1;   // 1 = seconds field, 0 = minutes field
    localparam int MODE_ADJ   = 2;
    localparam int MODE_CLR   = 3;

    localparam int SW_MODE_W  = 4;
    localparam int SW_MAX_VAL = 59;  // last value of a two-digit field before 00

endpackage

// File: rtl/stopwatch_counter_bcd_mod60.sv
// bcd_mod60
//   Two-digit BCD counter that wraps MAX_VAL -> 00. Synchronous clear has
//   priority over increment. wrap flags the increment that causes the wrap so
//   the parent can carry it into the next field.
// Ports
//   clk   in   1  rising-edge clock
//   reset in   1  asynchronous active-low clear
//   clr   in   1  synchronous clear to 00
//   inc   in   1  step +1 this cycle
//   tens  out  4  BCD tens digit
//   ones  out  4  BCD ones digit
//   wrap  out  1  combinational: inc while value == MAX_VAL
module bcd_mod60 #(
    parameter int MAX_VAL = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       wrap
);

    localparam logic [3:0] LP_TENS_MAX = 4'(MAX_VAL / 10);
    localparam logic [3:0] LP_ONES_MAX = 4'(MAX_VAL % 10);

    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       w_at_max;

    assign w_at_max = (r_tens == LP_TENS_MAX) && (r_ones == LP_ONES_MAX);
    assign wrap     = inc & w_at_max;
    assign tens     = r_tens;
    assign ones     = r_ones;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (clr) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (inc) begin
            if (w_at_max) begin
                r_tens <= 4'd0;
                r_ones <= 4'd0;
            end else if (r_ones == 4'd9) begin
                r_ones <= 4'd0;
                r_tens <= r_tens + 4'd1;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//   MM:SS time-keeping datapath. Counts seconds on tick_1hz in run mode,
//   steps the selected field on tick_adj in adjust mode, honours clear and
//   pause. Produces a one-cycle rollover pulse on 59:59 -> 00:00 and a blink
//   phase for the display mux while adjusting.
// Ports
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous active-low clear
//   mode       in   MODE_W  [0]=paused [1]=sel(1=sec) [2]=adj [3]=clear
//   tick_1hz   in   1       run-mode count strobe
//   tick_adj   in   1       adjust-mode step strobe
//   tick_blink in   1       blink toggle strobe
//   min_tens/min_ones/sec_tens/sec_ones  out 4  BCD digits
//   rollover   out  1       one-cycle pulse on run-mode 59:59 -> 00:00
//   blink      out  1       blank phase for the selected field in adjust
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int MAX_VAL = SW_MAX_VAL,
    parameter int MODE_W  = SW_MODE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [MODE_W-1:0] mode,
    input  logic              tick_1hz,
    input  logic              tick_adj,
    input  logic              tick_blink,
    output logic [3:0]        min_tens,
    output logic [3:0]        min_ones,
    output logic [3:0]        sec_tens,
    output logic [3:0]        sec_ones,
    output logic              rollover,
    output logic              blink
);

    logic w_clr, w_pause, w_adj, w_sel;
    logic w_run_tick, w_adj_tick;
    logic w_sec_inc, w_min_inc;
    logic w_sec_wrap, w_min_wrap;
    logic r_rollover, r_blink;

    assign w_clr   = mode[MODE_CLR];
    assign w_pause = mode[MODE_PAUSE];
    assign w_adj   = mode[MODE_ADJ];
    assign w_sel   = mode[MODE_SEL];

    // Priority clear > pause > adjust > run folded into two qualified strobes
    assign w_run_tick = ~w_clr & ~w_pause & ~w_adj & tick_1hz;
    assign w_adj_tick = ~w_clr & ~w_pause &  w_adj & tick_adj;

    // Seconds carry into minutes only in run mode; adjust never carries
    assign w_sec_inc = w_run_tick | (w_adj_tick & w_sel);
    assign w_min_inc = (w_run_tick & w_sec_wrap) | (w_adj_tick & ~w_sel);

    bcd_mod60 #(.MAX_VAL(MAX_VAL)) u_sec (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .inc   (w_sec_inc),
        .tens  (sec_tens),
        .ones  (sec_ones),
        .wrap  (w_sec_wrap)
    );

    bcd_mod60 #(.MAX_VAL(MAX_VAL)) u_min (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .inc   (w_min_inc),
        .tens  (min_tens),
        .ones  (min_ones),
        .wrap  (w_min_wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rollover <= 1'b0;
            r_blink    <= 1'b0;
        end else begin
            // Minute wrap under a run tick implies seconds wrapped too
            r_rollover <= w_run_tick & w_min_wrap;
            if (w_clr || !w_adj)
                r_blink <= 1'b0;
            else if (tick_blink)
                r_blink <= ~r_blink;   // keeps toggling while paused in adjust
        end
    end

    assign rollover = r_rollover;
    assign blink    = r_blink;

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;

    typedef struct {
        int sec;
        int mn;
        bit roll;
        bit blk;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] mode;
    logic       tick_1hz, tick_adj, tick_blink;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       rollover, blink;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    // Reference state: plain integers for the two fields
    int m_sec = 0;
    int m_min = 0;
    bit m_blk = 1'b0;

    stopwatch_counter dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .tick_1hz   (tick_1hz),
        .tick_adj   (tick_adj),
        .tick_blink (tick_blink),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .rollover   (rollover),
        .blink      (blink)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int dut_time();
        return (int'(min_tens) * 10 + int'(min_ones)) * 100 + int'(sec_tens) * 10 + int'(sec_ones);
    endfunction

    // Drive one cycle of stimulus and push the expected post-edge response
    task automatic step(input logic [3:0] m, input bit t1, input bit ta, input bit tb);
        exp_t e;
        int   t;
        @(negedge clk);
        mode = m; tick_1hz = t1; tick_adj = ta; tick_blink = tb;
        e.roll = 1'b0;
        if (m[3]) begin
            m_sec = 0; m_min = 0; m_blk = 1'b0;
        end else begin
            if (!m[0]) begin
                if (m[2]) begin
                    if (ta) begin
                        if (m[1]) m_sec = (m_sec + 1) % 60;
                        else      m_min = (m_min + 1) % 60;
                    end
                end else if (t1) begin
                    t = m_min * 60 + m_sec + 1;
                    e.roll = (t == 3600);
                    t = t % 3600;
                    m_min = t / 60;
                    m_sec = t % 60;
                end
            end
            if (!m[2])   m_blk = 1'b0;
            else if (tb) m_blk = ~m_blk;
        end
        e.sec = m_sec; e.mn = m_min; e.blk = m_blk;
        exp_q.push_back(e);
    endtask

    // Hold mode m with no strobes and let the monitor empty the queue
    task automatic drain(input logic [3:0] m);
        step(m, 0, 0, 0);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expectation per active edge while stimulus is running
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("digits", dut_time(), (e.mn / 10 * 10 + e.mn % 10) * 100 + e.sec);
                check("rollover", int'(rollover), int'(e.roll));
                check("blink", int'(blink), int'(e.blk));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, queue depth %0d", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; mode = 4'b0000;
        tick_1hz = 0; tick_adj = 0; tick_blink = 0;
        #12;
        check("reset_digits", dut_time(), 0);
        check("reset_roll", int'(rollover), 0);
        check("reset_blink", int'(blink), 0);
        @(negedge clk);
        reset = 1'b1;

        // 1: 61 seconds in run mode with idle cycles between ticks
        for (int i = 0; i < 61; i++) begin
            step(4'b0000, 1, 0, 0);
            step(4'b0000, 0, 1, 1);
        end
        drain(4'b0000);
        check("t1_0101", dut_time(), 101);

        // 2: preload 59:58 via adjust, then run through the wrap
        step(4'b1000, 0, 0, 0);
        for (int i = 0; i < 59; i++) step(4'b0100, 1, 1, 0);
        for (int i = 0; i < 58; i++) step(4'b0110, 0, 1, 0);
        step(4'b0000, 1, 0, 0);
        step(4'b0000, 1, 0, 0);
        step(4'b0000, 0, 0, 0);

        // 3: seconds adjust wraps without carrying into minutes
        step(4'b1000, 0, 0, 0);
        for (int i = 0; i < 58; i++) step(4'b0110, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(4'b0110, 1, 1, 1);

        // 4: minutes adjust ignores tick_1hz, blink toggles
        for (int i = 0; i < 4; i++) step(4'b0100, 1, 0, 1);
        step(4'b0100, 0, 1, 1);
        step(4'b0100, 0, 1, 0);
        step(4'b0000, 0, 0, 0);   // leaving adjust forces blink low

        // 5: pause freezes, then clear wins over pause
        step(4'b1000, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(4'b0000, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(4'b0001, 1, 1, 1);
        step(4'b0101, 1, 1, 1);   // paused in adjust: blink still toggles
        step(4'b1001, 1, 1, 1);

        // Full hour at one tick per cycle to hit the natural rollover
        for (int i = 0; i < 3605; i++) step(4'b0000, 1, 0, 0);

        // Randomized mixed traffic
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] m;
            m[3] = ($urandom_range(0, 31) == 0);
            m[0] = ($urandom_range(0, 5) == 0);
            m[2] = ($urandom_range(0, 1) == 1);
            m[1] = ($urandom_range(0, 1) == 1);
            step(m, ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        // 6: async reset mid-cycle at 12:34 with blink high
        step(4'b1000, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(4'b0100, 0, 1, 0);
        for (int i = 0; i < 34; i++) step(4'b0110, 0, 1, 0);
        step(4'b0110, 0, 0, 1);
        drain(4'b0110);
        check("t6_pre", dut_time(), 1234);
        reset = 1'b0;
        #1;
        check("t6_async_digits", dut_time(), 0);
        check("t6_async_blink", int'(blink), 0);
        m_sec = 0; m_min = 0; m_blk = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(4'b0000, 1, 0, 0);
        drain(4'b0000);
        check("t6_first_tick", dut_time(), 1);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
